// File: rtl/blocks_state.sv
// Breakout brick map: painter row readout plus level fill and hit clearing via req/ack.
// Hit ack one cycle after an IDLE request; requests wait (no ack) while the 16-cycle fill runs.
module blocks_state #(
    parameter int NUM_ROWS       = 16,
    parameter int BLOCKS_PER_ROW = 13,
    parameter int FILL_ROWS      = 8,
    localparam int ROW_W         = $clog2(NUM_ROWS),
    localparam int COL_W         = $clog2(BLOCKS_PER_ROW)
) (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic                      new_frame,
    input  logic                      go_next_line,
    output logic [BLOCKS_PER_ROW-1:0] block_line_state,
    input  logic                      level_load,
    output logic                      busy,
    input  logic                      hit_req,
    input  logic [ROW_W-1:0]          hit_row,
    input  logic [COL_W-1:0]          hit_col,
    output logic                      hit_ack,
    output logic                      hit_present,
    output logic [7:0]                blocks_left,
    output logic                      all_cleared
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_ACK,
        S_WAIT_LOW
    } state_e;

    typedef logic [BLOCKS_PER_ROW-1:0] row_t;

    state_e                  state_q, state_d;
    row_t [NUM_ROWS-1:0]     map_q, map_d;
    logic [ROW_W-1:0]        rd_row_q, rd_row_d;
    logic [ROW_W-1:0]        fill_cnt_q, fill_cnt_d;
    logic [7:0]              blocks_left_q, blocks_left_d;
    logic                    present_q, present_d;
    logic                    hit_valid;
    logic                    fill_row_on;

    // Out-of-range coordinates still get acked, but never touch the map.
    assign hit_valid   = (int'(hit_row) < NUM_ROWS) && (int'(hit_col) < BLOCKS_PER_ROW);
    assign fill_row_on = int'(fill_cnt_q) < FILL_ROWS;

    // Display pointer: frame start wins over a coincident row step.
    always_comb begin
        rd_row_d = rd_row_q;
        if (new_frame) begin
            rd_row_d = '0;
        end else if (go_next_line) begin
            if (rd_row_q == ROW_W'(NUM_ROWS - 1)) begin
                rd_row_d = '0;
            end else begin
                rd_row_d = rd_row_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        map_d         = map_q;
        fill_cnt_d    = fill_cnt_q;
        blocks_left_d = blocks_left_q;
        present_d     = present_q;

        case (state_q)
            S_IDLE: begin
                if (level_load) begin
                    state_d       = S_FILL;
                    fill_cnt_d    = '0;
                    blocks_left_d = '0;
                end else if (hit_req) begin
                    state_d   = S_ACK;
                    present_d = 1'b0;
                    if (hit_valid) begin
                        if (map_q[hit_row][hit_col]) begin
                            present_d = 1'b1;
                            if (blocks_left_q != 8'd0) begin
                                blocks_left_d = blocks_left_q - 8'd1;
                            end
                        end
                        map_d[hit_row][hit_col] = 1'b0;
                    end
                end
            end

            S_FILL: begin
                map_d[fill_cnt_q] = fill_row_on ? '1 : '0;
                if (fill_row_on) begin
                    blocks_left_d = blocks_left_q + 8'(BLOCKS_PER_ROW);
                end
                if (fill_cnt_q == ROW_W'(NUM_ROWS - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end

            S_ACK: begin
                state_d = S_WAIT_LOW;
            end

            // Holding hit_req past the ack must not retrigger a second clear.
            S_WAIT_LOW: begin
                if (!hit_req) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q       <= S_IDLE;
            map_q         <= '0;
            rd_row_q      <= '0;
            fill_cnt_q    <= '0;
            blocks_left_q <= '0;
            present_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            map_q         <= map_d;
            rd_row_q      <= rd_row_d;
            fill_cnt_q    <= fill_cnt_d;
            blocks_left_q <= blocks_left_d;
            present_q     <= present_d;
        end
    end

    assign block_line_state = map_q[rd_row_q];
    assign busy             = (state_q == S_FILL);
    assign hit_ack          = (state_q == S_ACK);
    assign hit_present      = (state_q == S_ACK) && present_q;
    assign blocks_left      = blocks_left_q;
    assign all_cleared      = (state_q == S_IDLE) && (blocks_left_q == 8'd0);

endmodule
